// File: rtl/display_scanner.sv
// Four-digit multiplexed 7-segment scan controller.
// It double-buffers each frame and applies a new frame only on the digit 3->0 wrap.
module display_scanner #(
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  BLANK_MASK,
  output logic        PENDING,
  output logic [1:0]  SEL,
  output logic [3:0]  DIGIT,
  output logic [3:0]  ANODE,
  output logic        FRAME_TICK
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   pdata_q, pdata_d;
  logic [3:0]    pmask_q, pmask_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          slot_end;
  logic          wrap;
  logic          in_blank;

  assign slot_end = (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (sel_q == 2'd3);

  if (BLANK_CYC == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (cnt_q < CW'(BLANK_CYC));
  end

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    sel_d   = slot_end ? sel_q + 2'd1 : sel_q;
    tick_d  = wrap;
    disp_d  = disp_q;
    mask_d  = mask_q;
    pdata_d = pdata_q;
    pmask_d = pmask_q;
    pend_d  = pend_q;
    // Apply first, then capture: a LOAD coinciding with the wrap refills the
    // pending buffer and leaves it flagged for the following frame.
    if (wrap && pend_q) begin
      disp_d = pdata_q;
      mask_d = pmask_q;
      pend_d = 1'b0;
    end
    if (LOAD) begin
      pdata_d = DATA_IN;
      pmask_d = BLANK_MASK;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      disp_q  <= '0;
      mask_q  <= '1;
      pdata_q <= '0;
      pmask_q <= '0;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      disp_q  <= disp_d;
      mask_q  <= mask_d;
      pdata_q <= pdata_d;
      pmask_q <= pmask_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

  assign PENDING    = pend_q;
  assign SEL        = sel_q;
  assign FRAME_TICK = tick_q;
  assign DIGIT      = disp_q[{sel_q, 2'b00} +: 4];
  assign ANODE      = (in_blank || mask_q[sel_q]) ? 4'b1111 : ~(4'b0001 << sel_q);

endmodule
